// File: rtl/tqvp_fir_pkg.sv
// Shared constants, types and helpers for the sequential-MAC FIR peripheral.
package tqvp_fir_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_IDX    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_COEFF  = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_SAMPLE = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUT    = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_RSVD   = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_UI     = 4'd7;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_SIGNED = 1;
  localparam int unsigned CTRL_SAT    = 2;
  localparam int unsigned CTRL_CLR    = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_OVR  = 2;

  // Persistent control bits, laid out to match the register's bit positions.
  typedef struct packed {
    logic sat;
    logic sgn;
    logic en;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    FINISH = 2'd2
  } fir_state_e;

  function automatic logic [3:0] wrap_idx(input logic [3:0] v, input int unsigned n);
    int unsigned t;
    t = 32'(v) % n;
    return 4'(t);
  endfunction

endpackage

// File: rtl/tqvp_seq_fir_if.sv
// tinyQV local peripheral bus: address, write strobe, write data and read data.
interface tqvp_seq_fir_if;
  import tqvp_fir_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              data_write;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_fir_mac.sv
// Shared 8x8 multiplier (signed or unsigned) feeding a clearable accumulator.
module tqvp_fir_mac #(
  parameter int unsigned ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    acc_en_i,
  input  logic                    signed_i,
  input  logic [7:0]              coef_i,
  input  logic [7:0]              sample_i,
  output logic signed [ACC_W-1:0] acc_o
);
  localparam int unsigned OP_W   = 9;
  localparam int unsigned PROD_W = 18;

  logic signed [OP_W-1:0]   coef_ext_c;
  logic signed [OP_W-1:0]   sample_ext_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // A 9-bit signed operand covers both the unsigned and two's-complement byte ranges.
  always_comb begin
    coef_ext_c   = {signed_i & coef_i[7], coef_i};
    sample_ext_c = {signed_i & sample_i[7], sample_i};
    prod_c       = PROD_W'(coef_ext_c) * PROD_W'(sample_ext_c);
    acc_d        = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/tqvp_seq_fir.sv
// Sequential-MAC FIR peripheral: one product per cycle over TAPS taps per sample.
// Define FIR_ROUND_EN to round half up before the output shift instead of truncating.
module tqvp_seq_fir
  import tqvp_fir_pkg::*;
#(
  parameter int unsigned TAPS  = 8,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned ACC_W = 16 + $clog2(TAPS) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  tqvp_seq_fir_if.slave bus
);
  localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned RES_W = ACC_W + 1;
  localparam logic [7:0]  COEF_RST = 8'(((256 / TAPS) > 255) ? 255 : (256 / TAPS));
  localparam logic [3:0]  IDX_LAST = 4'(TAPS - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

  localparam logic signed [RES_W-1:0] S_MAX = RES_W'(127);
  localparam logic signed [RES_W-1:0] S_MIN = RES_W'(-128);
  localparam logic signed [RES_W-1:0] U_MAX = RES_W'(255);
  localparam logic signed [RES_W-1:0] U_MIN = '0;
`ifdef FIR_ROUND_EN
  localparam logic signed [RES_W-1:0] RND = RES_W'((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0);
`else
  localparam logic signed [RES_W-1:0] RND = '0;
`endif

  fir_state_e       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       coef_q [TAPS];
  logic [7:0]       coef_d [TAPS];
  logic [7:0]       x_q [TAPS];
  logic [7:0]       x_d [TAPS];
  logic [7:0]       out_q, out_d;

  logic wr_ctrl_c, wr_stat_c, wr_idx_c, wr_coef_c, wr_samp_c;
  logic mac_clr_c, mac_en_c, abort_c;
  logic signed [ACC_W-1:0] mac_acc;
  logic signed [RES_W-1:0] pre_c, shifted_c;
  logic [7:0] y_c;
  logic [7:0] rd_data_c;

  assign wr_ctrl_c = bus.data_write && (bus.address == ADDR_CTRL);
  assign wr_stat_c = bus.data_write && (bus.address == ADDR_STATUS);
  assign wr_idx_c  = bus.data_write && (bus.address == ADDR_IDX);
  assign wr_coef_c = bus.data_write && (bus.address == ADDR_COEFF);
  assign wr_samp_c = bus.data_write && (bus.address == ADDR_SAMPLE);

  tqvp_fir_mac #(.ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (mac_clr_c),
    .acc_en_i (mac_en_c),
    .signed_i (ctrl_q.sgn),
    .coef_i   (coef_q[tap_q]),
    .sample_i (x_q[tap_q]),
    .acc_o    (mac_acc)
  );

  // Scale and clamp; unsigned accumulations never reach the sign bit, so one signed path serves both modes.
  always_comb begin
    pre_c     = RES_W'(mac_acc) + RND;
    shifted_c = pre_c >>> SHIFT;
    y_c       = shifted_c[7:0];
    if (ctrl_q.sat) begin
      if (ctrl_q.sgn) begin
        if (shifted_c > S_MAX)      y_c = 8'h7F;
        else if (shifted_c < S_MIN) y_c = 8'h80;
      end else begin
        if (shifted_c > U_MAX)      y_c = 8'hFF;
        else if (shifted_c < U_MIN) y_c = 8'h00;
      end
    end
  end

  // Register writes and FSM next state.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    ctrl_d    = ctrl_q;
    busy_d    = 1'b0;
    done_d    = done_q;
    ovr_d     = ovr_q;
    idx_d     = idx_q;
    coef_d    = coef_q;
    x_d       = x_q;
    out_d     = out_q;
    mac_clr_c = 1'b0;
    mac_en_c  = 1'b0;
    abort_c   = 1'b0;

    if (wr_ctrl_c) begin
      ctrl_d = ctrl_t'(bus.data_in[2:0]);
      if (bus.data_in[CTRL_CLR]) begin
        for (int unsigned k = 0; k < TAPS; k++) x_d[k] = '0;
        abort_c = (state_q != IDLE);
      end
    end
    if (wr_stat_c && bus.data_in[STAT_OVR]) ovr_d = 1'b0;
    if (wr_idx_c) idx_d = wrap_idx(bus.data_in[3:0], TAPS);
    if (wr_coef_c) begin
      coef_d[TAP_W'(idx_q)] = bus.data_in;
      idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (wr_samp_c) begin
          for (int unsigned k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          x_d[0] = bus.data_in;
          if (ctrl_q.en) begin
            done_d    = 1'b0;
            mac_clr_c = 1'b1;
            tap_d     = '0;
            state_d   = MAC;
          end
        end
      end
      MAC: begin
        mac_en_c = 1'b1;
        busy_d   = 1'b1;
        if (tap_q == TAP_LAST) begin
          tap_d   = '0;
          state_d = FINISH;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      FINISH: begin
        out_d   = y_c;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over a same-cycle write-1-clear.
    if (wr_samp_c && (state_q != IDLE)) ovr_d = 1'b1;

    if (abort_c) begin
      state_d  = IDLE;
      tap_d    = '0;
      busy_d   = 1'b0;
      mac_en_c = 1'b0;
      out_d    = out_q;
      done_d   = done_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      for (int unsigned k = 0; k < TAPS; k++) begin
        coef_q[k] <= COEF_RST;
        x_q[k]    <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      coef_q  <= coef_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (bus.address)
      ADDR_CTRL:   rd_data_c = {5'b0, ctrl_q};
      ADDR_STATUS: rd_data_c = {5'b0, ovr_q, done_q, busy_q};
      ADDR_IDX:    rd_data_c = {4'b0, idx_q};
      ADDR_COEFF:  rd_data_c = coef_q[TAP_W'(idx_q)];
      ADDR_SAMPLE: rd_data_c = x_q[0];
      ADDR_OUT:    rd_data_c = out_q;
      ADDR_RSVD:   rd_data_c = '0;
      ADDR_UI:     rd_data_c = ui_in;
      default:     rd_data_c = '0;
    endcase
  end

  assign bus.data_out = rd_data_c;
  assign uo_out       = out_q;

endmodule

// File: tb/tb_tqvp_seq_fir.sv
// Self-checking bench for tqvp_seq_fir (TAPS=8, SHIFT=8) against a behavioural FIR model.
module tb_tqvp_seq_fir;
  localparam int TAPS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  tqvp_seq_fir_if bus();

  tqvp_seq_fir #(.TAPS(8), .SHIFT(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_coef [TAPS];
  int m_x    [TAPS];
  int m_idx;
  bit m_sgn;
  bit m_sat;

  function automatic int sx(input int v, input bit s);
    return (s && v >= 128) ? v - 256 : v;
  endfunction

  // Direct convolution, floor-divide by 256, optional clamp, keep low byte.
  function automatic int model_y();
    int acc = 0;
    int r;
    for (int k = 0; k < TAPS; k++) acc += sx(m_coef[k], m_sgn) * sx(m_x[k], m_sgn);
    r = acc >>> 8;
    if (m_sat) begin
      if (m_sgn) r = (r > 127) ? 127 : ((r < -128) ? -128 : r);
      else       r = (r > 255) ? 255 : ((r < 0) ? 0 : r);
    end
    return r & 255;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = 32;
      m_x[k]    = 0;
    end
    m_idx = 0;
    m_sgn = 1'b0;
    m_sat = 1'b0;
  endfunction

  function automatic void m_push(input int v);
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = v;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.data_in    = d;
    bus.data_write = 1'b1;
    @(negedge clk);
    bus.data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.address = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic set_ctrl(input logic [7:0] v);
    wr(4'd0, v);
    m_sgn = v[1];
    m_sat = v[2];
    if (v[3]) for (int k = 0; k < TAPS; k++) m_x[k] = 0;
  endtask

  task automatic wr_coef(input logic [7:0] v);
    wr(4'd3, v);
    m_coef[m_idx] = int'(v);
    m_idx = (m_idx + 1) % TAPS;
  endtask

  task automatic push(input logic [7:0] v);
    wr(4'd4, v);
    m_push(int'(v));
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] s;
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      rd(4'd1, s);
      if (s[1]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout got=0 exp=1", tag);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    bus.address = '0; bus.data_in = '0; bus.data_write = 1'b0;
    ui_in = 8'($urandom_range(255));
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'd1, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", d); end
    rd(4'd5, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", d); end
    rd(4'd0, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", d); end
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo got=%h exp=00", uo_out); end
    @(negedge clk);
    rd(4'd2, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_idx got=%h exp=00", d); end
    rd(4'd3, d); checks++; if (d !== 8'd32) begin errors++; $display("FAIL reset_coef got=%h exp=20", d); end
    rd(4'd4, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_x0 got=%h exp=00", d); end
    rd(4'd6, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL addr6 got=%h exp=00", d); end
    @(negedge clk);
    rd(4'd7, d); checks++; if (d !== ui_in) begin errors++; $display("FAIL ui_read got=%h exp=%h", d, ui_in); end
    rd(4'hA, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped got=%h exp=00", d); end
  endtask

  task automatic test_latency();
    logic [7:0] s, d;
    bit eb, ed;
    set_ctrl(8'h01);
    push(8'd200);
    for (int n = 0; n <= 9; n++) begin
      rd(4'd1, s);
      eb = (n >= 1 && n <= 8);
      ed = (n == 9);
      checks++;
      if (s[0] !== eb || s[1] !== ed) begin
        errors++;
        $display("FAIL latency_edge%0d busy/done got=%b%b exp=%b%b", n, s[0], s[1], eb, ed);
      end
      @(negedge clk);
    end
    rd(4'd5, d); checks++; if (d !== 8'd25) begin errors++; $display("FAIL first_avg got=%0d exp=25", d); end
    for (int i = 0; i < 7; i++) begin
      push(8'd200);
      wait_done("avg");
    end
    rd(4'd5, d); checks++; if (d !== 8'd200) begin errors++; $display("FAIL full_avg got=%0d exp=200", d); end
    checks++; if (uo_out !== 8'd200) begin errors++; $display("FAIL full_avg_uo got=%0d exp=200", uo_out); end
  endtask

  task automatic test_overrun();
    logic [7:0] s, d;
    set_ctrl(8'h09);
    push(8'd100);
    repeat (2) @(negedge clk);
    wr(4'd4, 8'd50);
    rd(4'd1, s); checks++; if (s[2] !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", s[2]); end
    rd(4'd4, d); checks++; if (d !== 8'd100) begin errors++; $display("FAIL overrun_x0 got=%0d exp=100", d); end
    wait_done("overrun");
    rd(4'd5, d); checks++; if (d !== 8'd12 || int'(d) !== model_y()) begin errors++; $display("FAIL overrun_out got=%0d exp=12", d); end
    wr(4'd1, 8'h04);
    rd(4'd1, s); checks++; if (s !== 8'h02) begin errors++; $display("FAIL overrun_clear got=%h exp=02", s); end
  endtask

  task automatic test_saturation();
    logic [7:0] d;
    set_ctrl(8'h0D);
    wr(4'd2, 8'd0); m_idx = 0;
    for (int i = 0; i < TAPS; i++) wr_coef(8'd255);
    rd(4'd2, d); checks++; if (d !== 8'd0) begin errors++; $display("FAIL idx_wrap got=%0d exp=0", d); end
    rd(4'd3, d); checks++; if (d !== 8'd255) begin errors++; $display("FAIL coef_read got=%0d exp=255", d); end
    for (int i = 0; i < TAPS; i++) begin
      push(8'd255);
      wait_done("sat");
    end
    rd(4'd5, d); checks++; if (d !== 8'hFF) begin errors++; $display("FAIL sat_on got=%h exp=ff", d); end
    set_ctrl(8'h01);
    push(8'd255);
    wait_done("nosat");
    rd(4'd5, d); checks++; if (d !== 8'hF0) begin errors++; $display("FAIL sat_off got=%h exp=f0", d); end
  endtask

  task automatic test_signed();
    logic [7:0] d;
    set_ctrl(8'h0B);
    wr(4'd2, 8'd0); m_idx = 0;
    wr_coef(8'h7F);
    for (int i = 1; i < TAPS; i++) wr_coef(8'h00);
    push(8'h80);
    wait_done("signed1");
    rd(4'd5, d); checks++; if (d !== 8'hC0) begin errors++; $display("FAIL signed_neg got=%h exp=c0", d); end
    wr(4'd2, 8'd0); m_idx = 0;
    wr_coef(8'h80);
    push(8'h80);
    wait_done("signed2");
    rd(4'd5, d); checks++; if (d !== 8'h40) begin errors++; $display("FAIL signed_pos got=%h exp=40", d); end
  endtask

  task automatic test_random();
    logic [7:0] d, v, r;
    int exp;
    for (int round = 0; round < 4; round++) begin
      v = 8'h09 | 8'($urandom_range(1) << 1) | 8'($urandom_range(1) << 2);
      set_ctrl(v);
      r = 8'($urandom_range(15));
      wr(4'd2, r); m_idx = int'(r) % TAPS;
      for (int i = 0; i < TAPS; i++) wr_coef(8'($urandom_range(255)));
      r = 8'($urandom_range(15));
      wr(4'd2, r);
      m_idx = int'(r) % TAPS;
      rd(4'd3, d); checks++;
      if (int'(d) !== m_coef[m_idx]) begin errors++; $display("FAIL rnd_coef idx=%0d got=%0d exp=%0d", r, d, m_coef[m_idx]); end
      for (int i = 0; i < 6; i++) begin
        v = 8'($urandom_range(255));
        push(v);
        wait_done("rnd");
        exp = model_y();
        rd(4'd5, d); checks++;
        if (int'(d) !== exp) begin errors++; $display("FAIL rnd_out r%0d s%0d got=%0d exp=%0d", round, i, d, exp); end
        rd(4'd4, d); checks++;
        if (d !== v) begin errors++; $display("FAIL rnd_x0 got=%0d exp=%0d", d, v); end
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] prev, s, d;
    set_ctrl(8'h01);
    rd(4'd5, prev);
    push(8'h33);
    repeat (2) @(negedge clk);
    set_ctrl(8'h09);
    rd(4'd1, s); checks++; if (s !== 8'h00) begin errors++; $display("FAIL abort_status got=%h exp=00", s); end
    rd(4'd4, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_x0 got=%h exp=00", d); end
    rd(4'd0, d); checks++; if (d !== 8'h01) begin errors++; $display("FAIL abort_ctrl got=%h exp=01", d); end
    repeat (12) @(negedge clk);
    rd(4'd1, s); checks++; if (s !== 8'h00) begin errors++; $display("FAIL abort_late_status got=%h exp=00", s); end
    rd(4'd5, d); checks++; if (d !== prev) begin errors++; $display("FAIL abort_out got=%h exp=%h", d, prev); end
  endtask

  task automatic test_disable();
    logic [7:0] prev, s, d;
    int exp;
    set_ctrl(8'h00);
    rd(4'd5, prev);
    push(8'd77);
    repeat (12) @(negedge clk);
    rd(4'd1, s); checks++; if (s[0] !== 1'b0) begin errors++; $display("FAIL disable_busy got=%b exp=0", s[0]); end
    rd(4'd4, d); checks++; if (d !== 8'd77) begin errors++; $display("FAIL disable_x0 got=%0d exp=77", d); end
    rd(4'd5, d); checks++; if (d !== prev) begin errors++; $display("FAIL disable_hold got=%h exp=%h", d, prev); end
    set_ctrl(8'h01);
    push(8'd10);
    wait_done("reenable");
    exp = model_y();
    rd(4'd5, d); checks++; if (int'(d) !== exp) begin errors++; $display("FAIL reenable_out got=%0d exp=%0d", d, exp); end
  endtask

  task automatic test_async_reset();
    logic [7:0] s, d;
    set_ctrl(8'h01);
    push(8'd150);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL areset_uo got=%h exp=00", uo_out); end
    rd(4'd1, s); checks++; if (s !== 8'h00) begin errors++; $display("FAIL areset_status got=%h exp=00", s); end
    @(negedge clk);
    rd(4'd5, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL areset_out got=%h exp=00", d); end
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'd2, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL areset_idx got=%h exp=00", d); end
    rd(4'd3, d); checks++; if (d !== 8'd32) begin errors++; $display("FAIL areset_coef got=%0d exp=32", d); end
    rd(4'd0, d); checks++; if (d !== 8'h00) begin errors++; $display("FAIL areset_ctrl got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overrun();
    test_saturation();
    test_signed();
    test_random();
    test_abort();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
